// File: rtl/mem_writeback_if.sv
// rtl/mem_writeback_if.sv - execute/RAM/register-file bundle for the c16 memory/writeback stage
interface mem_writeback_if #(
  parameter int DATA_W = 16
);
  logic              ex_valid;
  logic              ex_ready;
  logic [1:0]        ex_kind;
  logic [2:0]        ex_dest;
  logic [DATA_W-1:0] ex_value;
  logic [DATA_W-1:0] ex_store_data;
  logic              flush;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_enable;
  logic [2:0]        wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              busy;

  modport master (
    output ex_valid, ex_kind, ex_dest, ex_value, ex_store_data, flush, mem_rdata,
    input  ex_ready, mem_addr, mem_wdata, mem_wren, mem_rden, wb_enable, wb_dest, wb_value, busy
  );

  modport slave (
    input  ex_valid, ex_kind, ex_dest, ex_value, ex_store_data, flush, mem_rdata,
    output ex_ready, mem_addr, mem_wdata, mem_wren, mem_rden, wb_enable, wb_dest, wb_value, busy
  );
endinterface

// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - c16 memory/writeback stage; drives RAM port b and the register-file write
module mem_writeback #(
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input logic            clk,
  input logic            CPU_RESET_n,
  mem_writeback_if.slave bus
);
  localparam logic [1:0] KIND_ALU = 2'd0;
  localparam logic [1:0] KIND_LD  = 2'd1;
  localparam logic [1:0] KIND_ST  = 2'd2;
  localparam logic [2:0] DEST_R7  = 3'd7;

  typedef enum logic {IDLE, LD_WAIT} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [2:0] ld_dest;

  // Execute only stalls during a load; reset also holds it off.
  assign bus.ex_ready = (state == IDLE) && CPU_RESET_n;
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      ld_dest       <= 3'd0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wren  <= 1'b0;
      bus.mem_rden  <= 1'b0;
      bus.wb_enable <= 1'b0;
      bus.wb_dest   <= 3'd0;
      bus.wb_value  <= '0;
    end else begin
      bus.wb_enable <= 1'b0;
      bus.mem_wren  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ex_valid) begin
            case (bus.ex_kind)
              KIND_ALU: begin
                bus.wb_enable <= (bus.ex_dest != DEST_R7);
                bus.wb_dest   <= bus.ex_dest;
                bus.wb_value  <= bus.ex_value;
              end
              KIND_ST: begin
                bus.mem_addr  <= bus.ex_value;
                bus.mem_wdata <= bus.ex_store_data;
                bus.mem_wren  <= 1'b1;
              end
              KIND_LD: begin
                bus.mem_addr <= bus.ex_value;
                bus.mem_rden <= 1'b1;
                ld_dest      <= bus.ex_dest;
                cnt          <= 3'(MEM_LATENCY);
                state        <= LD_WAIT;
              end
              default: ;
            endcase
          end
        end
        LD_WAIT: begin
          // Flush beats a load that would complete on this same edge.
          if (bus.flush) begin
            bus.mem_rden <= 1'b0;
            state        <= IDLE;
          end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            bus.wb_value  <= bus.mem_rdata;
            bus.wb_dest   <= ld_dest;
            bus.wb_enable <= (ld_dest != DEST_R7);
            bus.mem_rden  <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_writeback.sv
// tb/tb_mem_writeback.sv - scoreboard bench for mem_writeback with a latency-3 RAM model
module tb_mem_writeback;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_writeback_if #(.DATA_W(DW)) bus();
  mem_writeback #(.DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .CPU_RESET_n(rst_n), .bus(bus)
  );

  logic [15:0] ram    [256];
  logic [15:0] shadow [256];
  logic [15:0] pipe   [LAT];
  logic [18:0] wb_q [$];
  logic [31:0] st_q [$];
  int compared   = 0;
  int mismatched = 0;

  // RAM: address sampled each edge, q appears LAT edges after the sample.
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    pipe[0] <= ram[bus.mem_addr[7:0]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  always @(negedge clk) begin
    if (rst_n && bus.wb_enable) begin
      compared++;
      if (wb_q.size() == 0) begin
        mismatched++;
        $display("FAIL wb_unexpected: got dest %0d value %h, want no writeback", bus.wb_dest, bus.wb_value);
      end else begin
        logic [18:0] e;
        e = wb_q.pop_front();
        if ({bus.wb_dest, bus.wb_value} !== e) begin
          mismatched++;
          $display("FAIL wb_scoreboard: got dest %0d value %h, want dest %0d value %h", bus.wb_dest, bus.wb_value, e[18:16], e[15:0]);
        end
      end
    end
    if (rst_n && bus.mem_wren) begin
      compared++;
      if (st_q.size() == 0) begin
        mismatched++;
        $display("FAIL st_unexpected: got write %h <= %h, want no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [31:0] s;
        s = st_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== s) begin
          mismatched++;
          $display("FAIL st_scoreboard: got %h <= %h, want %h <= %h", bus.mem_addr, bus.mem_wdata, s[31:16], s[15:0]);
        end
      end
    end
  end

  task automatic send(input logic [1:0] k, input logic [2:0] d, input logic [15:0] v,
                      input logic [15:0] sd, input bit expect_wb, output int w);
    @(negedge clk);
    bus.ex_valid = 1'b1; bus.ex_kind = k; bus.ex_dest = d;
    bus.ex_value = v; bus.ex_store_data = sd;
    w = 0;
    while (!bus.ex_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout: got ex_ready=0 for %0d cycles, want 1", w);
      bus.ex_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    case (k)
      2'd0: if (d != 3'd7) wb_q.push_back({d, v});
      2'd1: if (d != 3'd7 && expect_wb) wb_q.push_back({d, shadow[v[7:0]]});
      2'd2: begin st_q.push_back({v, sd}); shadow[v[7:0]] = sd; end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    bus.ex_valid = 0; bus.ex_kind = 0; bus.ex_dest = 0; bus.ex_value = 0;
    bus.ex_store_data = 0; bus.flush = 0;
    repeat (2) @(posedge clk); #1;
    compared++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wren, bus.mem_rden, bus.wb_enable, bus.wb_dest,
         bus.wb_value, bus.ex_ready, bus.busy} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got addr %h wren %b rden %b wb %b ready %b, want all 0",
               bus.mem_addr, bus.mem_wren, bus.mem_rden, bus.wb_enable, bus.ex_ready);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    compared++;
    if (bus.ex_ready !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: got ready %b busy %b, want 1 0", bus.ex_ready, bus.busy);
    end
  endtask

  task automatic test_alu();
    int w;
    send(2'd0, 3'd3, 16'h1234, 16'h0, 1, w);
    compared++;
    if ({bus.wb_enable, bus.wb_dest, bus.wb_value} !== {1'b1, 3'd3, 16'h1234}) begin
      mismatched++;
      $display("FAIL alu_wb: got %b %0d %h, want 1 3 1234", bus.wb_enable, bus.wb_dest, bus.wb_value);
    end
  endtask

  task automatic test_st_ld();
    int w, n;
    send(2'd2, 3'd0, 16'h0020, 16'hBEEF, 1, w);
    compared++;
    if ({bus.mem_wren, bus.mem_addr, bus.mem_wdata} !== {1'b1, 16'h0020, 16'hBEEF}) begin
      mismatched++;
      $display("FAIL st_port: got %b %h %h, want 1 0020 beef", bus.mem_wren, bus.mem_addr, bus.mem_wdata);
    end
    send(2'd1, 3'd2, 16'h0020, 16'h0, 1, w);
    compared++;
    if ({bus.mem_wren, bus.mem_rden, bus.busy} !== 3'b011) begin
      mismatched++;
      $display("FAIL ld_issue: got wren %b rden %b busy %b, want 0 1 1", bus.mem_wren, bus.mem_rden, bus.busy);
    end
    n = 0;
    while (!bus.wb_enable && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    compared++;
    if (n !== LAT + 1 || bus.wb_value !== 16'hBEEF || bus.wb_dest !== 3'd2) begin
      mismatched++;
      $display("FAIL st_ld_forward: got %0d cycles value %h dest %0d, want %0d beef 2", n, bus.wb_value, bus.wb_dest, LAT + 1);
    end
  endtask

  task automatic test_stall();
    int w;
    send(2'd1, 3'd4, 16'h0030, 16'h0, 1, w);
    send(2'd0, 3'd6, 16'hA5A5, 16'h0, 1, w);
    compared++;
    if (w !== LAT + 1) begin
      mismatched++;
      $display("FAIL ld_stall: got ex_ready low %0d cycles, want %0d", w, LAT + 1);
    end
  endtask

  task automatic test_dest7();
    int w;
    bit seen;
    send(2'd1, 3'd7, 16'h0040, 16'h0, 0, w);
    compared++;
    if (bus.mem_rden !== 1'b1) begin
      mismatched++;
      $display("FAIL r7_rden: got %b, want 1", bus.mem_rden);
    end
    seen = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (bus.wb_enable) seen = 1;
    end
    compared++;
    if (seen || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL r7_ld_wb: got wb seen %b busy %b, want 0 0", seen, bus.busy);
    end
    send(2'd0, 3'd7, 16'h7777, 16'h0, 1, w);
    compared++;
    if (bus.wb_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL r7_alu_wb: got %b, want 0", bus.wb_enable);
    end
  endtask

  task automatic test_flush();
    int w;
    bit seen;
    send(2'd1, 3'd5, 16'h0050, 16'h0, 0, w);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    compared++;
    if ({bus.busy, bus.mem_rden, bus.wb_enable, bus.ex_ready} !== 4'b0001) begin
      mismatched++;
      $display("FAIL flush_ld: got busy %b rden %b wb %b ready %b, want 0 0 0 1", bus.busy, bus.mem_rden, bus.wb_enable, bus.ex_ready);
    end
    send(2'd1, 3'd5, 16'h0051, 16'h0, 0, w);
    repeat (LAT) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    seen = bus.wb_enable;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.wb_enable) seen = 1;
    end
    compared++;
    if (seen || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_cnt0: got wb seen %b busy %b, want 0 0", seen, bus.busy);
    end
    bus.flush = 1'b1;
    send(2'd0, 3'd1, 16'h4321, 16'h0, 1, w);
    compared++;
    if ({bus.wb_enable, bus.wb_value} !== {1'b1, 16'h4321}) begin
      mismatched++;
      $display("FAIL flush_idle_alu: got %b %h, want 1 4321", bus.wb_enable, bus.wb_value);
    end
    send(2'd2, 3'd0, 16'h0052, 16'hCAFE, 1, w);
    bus.flush = 1'b0;
    compared++;
    if (bus.mem_wren !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_idle_st: got wren %b, want 1", bus.mem_wren);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    bit seen;
    send(2'd1, 3'd1, 16'h0060, 16'h0, 0, w);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    compared++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wren, bus.mem_rden, bus.wb_enable, bus.wb_dest,
         bus.wb_value, bus.ex_ready, bus.busy} !== '0) begin
      mismatched++;
      $display("FAIL reset_async: got addr %h rden %b ready %b busy %b, want all 0",
               bus.mem_addr, bus.mem_rden, bus.ex_ready, bus.busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.ex_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_ready: got %b, want 1", bus.ex_ready);
    end
    seen = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (bus.wb_enable || bus.mem_wren) seen = 1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL reset_mid_stale: got stray writeback/write %b, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int w, n;
    for (int i = 0; i < 24; i++) begin
      logic [1:0] k;
      logic [2:0] d;
      logic [15:0] v;
      k = 2'($urandom_range(0, 3));
      d = 3'($urandom_range(0, 7));
      v = (k == 2'd0) ? 16'($urandom) : 16'(16'h0080 + $urandom_range(0, 7));
      send(k, d, v, 16'($urandom), 1, w);
    end
    n = 0;
    while ((wb_q.size() != 0 || st_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    compared++;
    if (wb_q.size() != 0 || st_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d wb and %0d st outstanding, want 0 0", wb_q.size(), st_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'(i * 16'h0101) ^ 16'h5A5A;
      shadow[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    for (int i = 0; i < LAT; i++) pipe[i] = 16'h0;
    test_reset();
    test_alu();
    test_st_ld();
    test_stall();
    test_dest7();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
